// File: rtl/pc_call_stack.sv
// Program counter with jump load, CALL/RET return-address stack
// and sticky stack overflow/underflow flags.
//
// Ports:
//   clk      system clock; every state change happens on posedge
//   clr      synchronous active-high reset; beats every other control
//   CP       count:  pc <= pc + 1 (wraps modulo 2**AW)
//   LP       jump:   pc <= din
//   CALL     push pc + 1 onto the return stack, then pc <= din
//   RET      pop the stack top into pc
//   EP       output enable: bus_out = EP ? pc : 0
//   din      jump/call target taken from the W-bus
//   pc       registered program counter
//   bus_out  OR-muxed bus driver; zero while EP is low
//   sp       stack occupancy, 0..DEPTH
//   ovf      sticky: a CALL arrived while the stack was full
//   unf      sticky: a RET arrived while the stack was empty
//
// Control priority: clr > RET > CALL > LP > CP > hold.

module pc_call_stack #(
    parameter int AW       = 4,
    parameter int DEPTH    = 4,
    parameter int RST_ADDR = 0,
    localparam int SW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          CP,
    input  logic          LP,
    input  logic          CALL,
    input  logic          RET,
    input  logic          EP,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] bus_out,
    output logic [SW-1:0] sp,
    output logic          ovf,
    output logic          unf
);

    // Stack index width; at least one bit so DEPTH == 1 still
    // yields a legal slice of sp.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] RST_PC = AW'(RST_ADDR);
    localparam logic [SW-1:0] SP_MAX = SW'(DEPTH);

    // Return-address storage. No reset: entries above sp are
    // never read, so their contents do not matter.
    logic [AW-1:0] stack [DEPTH];

    logic          full;
    logic          empty;
    logic [AW-1:0] pc_inc;
    logic [SW-1:0] sp_dec;
    logic [AW-1:0] top;

    // One-hot decoded controls after priority resolution.
    logic do_ret;
    logic do_call;
    logic do_lp;
    logic do_cp;

    // Actual stack movements (a blocked CALL/RET only flags).
    logic push;
    logic pop;

    logic [AW-1:0] pc_nxt;
    logic [SW-1:0] sp_nxt;
    logic          ovf_nxt;
    logic          unf_nxt;

    assign full   = (sp == SP_MAX);
    assign empty  = (sp == '0);
    assign pc_inc = pc + AW'(1);
    assign sp_dec = sp - SW'(1);
    assign top    = stack[sp_dec[IW-1:0]];

    assign do_ret  = RET;
    assign do_call = CALL && !RET;
    assign do_lp   = LP && !CALL && !RET;
    assign do_cp   = CP && !LP && !CALL && !RET;

    assign push = do_call && !full;
    assign pop  = do_ret && !empty;

    always_comb begin
        pc_nxt  = pc;
        sp_nxt  = sp;
        ovf_nxt = ovf;
        unf_nxt = unf;
        unique case (1'b1)
            do_ret: begin
                if (empty) begin
                    unf_nxt = 1'b1;
                end else begin
                    pc_nxt = top;
                    sp_nxt = sp_dec;
                end
            end
            do_call: begin
                if (full) begin
                    ovf_nxt = 1'b1;
                end else begin
                    pc_nxt = din;
                    sp_nxt = sp + SW'(1);
                end
            end
            do_lp: begin
                pc_nxt = din;
            end
            do_cp: begin
                pc_nxt = pc_inc;
            end
            default: begin
                pc_nxt = pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pc  <= RST_PC;
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            pc  <= pc_nxt;
            sp  <= sp_nxt;
            ovf <= ovf_nxt;
            unf <= unf_nxt;
        end
    end

    // Push writes the return address into the slot sp points at;
    // a clr in the same cycle cancels the push.
    always_ff @(posedge clk) begin
        if (!clr && push) begin
            stack[sp[IW-1:0]] <= pc_inc;
        end
    end

    // pop is consumed through pc_nxt; keep it named for clarity.
    logic unused_pop;
    assign unused_pop = pop;

    // Bus driver is purely combinational from EP and the pc register.
    assign bus_out = EP ? pc : '0;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack (AW=4, DEPTH=4, RST_ADDR=0).
// Table of per-cycle vectors plus hand-written corner sequences.

module tb_pc_call_stack;

    logic       clk = 1'b0;
    logic       clr, CP, LP, CALL, RET, EP;
    logic [3:0] din;
    logic [3:0] pc;
    logic [3:0] bus_out;
    logic [2:0] sp;
    logic       ovf, unf;

    int checks   = 0;
    int failures = 0;

    pc_call_stack #(
        .AW(4),
        .DEPTH(4),
        .RST_ADDR(0)
    ) dut (
        .clk(clk),
        .clr(clr),
        .CP(CP),
        .LP(LP),
        .CALL(CALL),
        .RET(RET),
        .EP(EP),
        .din(din),
        .pc(pc),
        .bus_out(bus_out),
        .sp(sp),
        .ovf(ovf),
        .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int clr, cp, lp, call, ret, ep;
        int din;
        int pc, sp, ovf, unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int c_clr, input int c_cp,
                       input int c_lp, input int c_call,
                       input int c_ret, input int c_ep,
                       input int c_din, input int e_pc,
                       input int e_sp, input int e_ovf,
                       input int e_unf);
        vec_t v;
        v.clr  = c_clr;
        v.cp   = c_cp;
        v.lp   = c_lp;
        v.call = c_call;
        v.ret  = c_ret;
        v.ep   = c_ep;
        v.din  = c_din;
        v.pc   = e_pc;
        v.sp   = e_sp;
        v.ovf  = e_ovf;
        v.unf  = e_unf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d want=%0d",
                     name, idx, act, exp);
        end
    endtask

    task automatic drive(input int c_clr, input int c_cp,
                         input int c_lp, input int c_call,
                         input int c_ret, input int c_ep,
                         input int c_din);
        clr  = c_clr[0];
        CP   = c_cp[0];
        LP   = c_lp[0];
        CALL = c_call[0];
        RET  = c_ret[0];
        EP   = c_ep[0];
        din  = c_din[3:0];
    endtask

    task automatic check_state(input int idx, input int e_pc,
                               input int e_sp, input int e_ovf,
                               input int e_unf, input int e_ep);
        chk("pc", idx, int'(pc), e_pc);
        chk("sp", idx, int'(sp), e_sp);
        chk("ovf", idx, int'(ovf), e_ovf);
        chk("unf", idx, int'(unf), e_unf);
        chk("bus_out", idx, int'(bus_out), e_ep != 0 ? e_pc : 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset
        add(1,0,0,0,0,0, 0,  0,0,0,0);
        // Count and wrap, EP low: pc 1..15,0,1
        for (int i = 1; i <= 17; i++)
            add(0,1,0,0,0,0, 0,  i % 16,0,0,0);
        // Jump; LP+CP takes din, not din+1
        add(0,0,1,0,0,0, 3,  3,0,0,0);
        add(0,0,1,0,0,1, 9,  9,0,0,0);
        add(0,1,1,0,0,0, 4,  4,0,0,0);
        // Call/return
        add(0,0,1,0,0,0, 5,  5,0,0,0);
        add(0,0,0,1,0,1, 12, 12,1,0,0);
        add(0,1,0,0,0,0, 0,  13,1,0,0);
        add(0,1,0,0,0,0, 0,  14,1,0,0);
        add(0,0,0,0,1,1, 0,  6,0,0,0);
        // Nesting to full, then overflow
        add(0,0,1,0,0,0, 1,  1,0,0,0);
        add(0,0,0,1,0,0, 2,  2,1,0,0);
        add(0,0,0,1,0,0, 3,  3,2,0,0);
        add(0,0,0,1,0,0, 4,  4,3,0,0);
        add(0,0,0,1,0,0, 5,  5,4,0,0);
        add(0,0,0,1,0,1, 9,  5,4,1,0);
        add(0,0,0,0,1,0, 0,  5,3,1,0);
        add(0,0,0,0,1,0, 0,  4,2,1,0);
        add(0,0,0,0,1,0, 0,  3,1,1,0);
        add(0,0,0,0,1,1, 0,  2,0,1,0);
        // Underflow, then return address wrap 15+1 -> 0
        add(0,0,0,0,1,0, 0,  2,0,1,1);
        add(0,0,1,0,0,0, 15, 15,0,1,1);
        add(0,0,0,1,0,0, 7,  7,1,1,1);
        add(0,0,0,0,1,1, 0,  0,0,1,1);
        // Priority: CALL beats LP/CP, RET beats CALL
        add(0,0,1,0,0,0, 8,  8,0,1,1);
        add(0,1,1,1,0,0, 3,  3,1,1,1);
        add(0,0,0,1,1,1, 11, 9,0,1,1);
        // Idle holds everything
        add(0,0,0,0,0,1, 6,  9,0,1,1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].cp, vecs[i].lp,
                  vecs[i].call, vecs[i].ret, vecs[i].ep,
                  vecs[i].din);
            @(posedge clk);
            #1;
            check_state(i, vecs[i].pc, vecs[i].sp,
                        vecs[i].ovf, vecs[i].unf, vecs[i].ep);
        end

        // EP reaches bus_out with no clock edge in between
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("ep_on_comb", 100, int'(bus_out), 9);
        EP = 1'b0;
        #1;
        chk("ep_off_comb", 101, int'(bus_out), 0);

        // Reset in the middle of a stacked state: sp=2, pc=10
        drive(0, 0, 0, 1, 0, 0, 1);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 0, 0, 10);
        @(posedge clk);
        #1;
        check_state(200, 10, 2, 1, 1, 0);
        drive(1, 1, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        check_state(201, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        #1;
        check_state(202, 0, 0, 0, 0, 1);
        // Stack is empty after reset: RET underflows
        drive(0, 0, 0, 0, 1, 1, 0);
        @(posedge clk);
        #1;
        check_state(203, 0, 0, 0, 1, 1);
        drive(0, 1, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        check_state(204, 1, 0, 0, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
